// File: rtl/zap_fetch_queue.sv
// Fetch queue between I-cache and decode: buffers returns while decode is stalled,
// bypasses straight to the output register when empty, and sleeps after an abort.
module zap_fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear_from_writeback,
  input  logic              i_data_stall,
  input  logic              i_clear_from_alu,
  input  logic              i_stall_from_shifter,
  input  logic              i_stall_from_issue,
  input  logic              i_stall_from_decode,
  input  logic [31:0]       i_pc_ff,
  input  logic [31:0]       i_cpsr_ff,
  input  logic [31:0]       i_instruction,
  input  logic              i_valid,
  input  logic              i_instr_abort,
  output logic              o_fetch_stall,
  output logic [31:0]       o_instruction,
  output logic              o_valid,
  output logic              o_instr_abort,
  output logic [31:0]       o_pc_plus_8_ff,
  output logic [PTR_W:0]    o_level
);

  localparam int T_BIT = 5;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic             abort_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             sleep_q, sleep_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc8_q, pc8_d;

  logic        clear, any_stall, full, empty;
  logic        push, advance, bypass, pop, enq;
  logic [31:0] new_instr, new_pc;
  logic        unused_cpsr;

  assign unused_cpsr = ^{i_cpsr_ff[31:T_BIT+1], i_cpsr_ff[T_BIT-1:0]};

  // A data stall masks the ALU flush; the writeback flush always wins.
  assign clear     = i_clear_from_writeback | (i_clear_from_alu & ~i_data_stall);
  assign any_stall = i_data_stall | i_stall_from_shifter | i_stall_from_issue |
                     i_stall_from_decode;
  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign push      = (i_valid | i_instr_abort) & ~full & ~sleep_q & ~clear;
  assign advance   = ~any_stall & ~clear;
  assign bypass    = advance & empty & push;
  assign pop       = advance & ~empty;
  assign enq       = push & ~bypass;
  assign new_instr = i_instr_abort ? 32'd0 : i_instruction;
  assign new_pc    = i_pc_ff + (i_cpsr_ff[T_BIT] ? 32'd4 : 32'd8);

  assign o_fetch_stall  = full;
  assign o_level        = level_q;
  assign o_valid        = valid_q;
  assign o_instr_abort  = abort_q;
  assign o_instruction  = instr_q;
  assign o_pc_plus_8_ff = pc8_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sleep_d  = sleep_q;
    valid_d  = valid_q;
    abort_d  = abort_q;
    instr_d  = instr_q;
    pc8_d    = pc8_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      sleep_d  = 1'b0;
      valid_d  = 1'b0;
      abort_d  = 1'b0;
      instr_d  = 32'd0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
      if (push && i_instr_abort) sleep_d = 1'b1;
      if (pop) begin
        valid_d = 1'b1;
        abort_d = abort_mem[rd_ptr_q];
        instr_d = instr_mem[rd_ptr_q];
        pc8_d   = pc_mem[rd_ptr_q];
      end else if (bypass) begin
        valid_d = 1'b1;
        abort_d = i_instr_abort;
        instr_d = new_instr;
        pc8_d   = new_pc;
      end else if (advance) begin
        valid_d = 1'b0;
        abort_d = 1'b0;
        instr_d = 32'd0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sleep_q  <= 1'b0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
      instr_q  <= 32'd0;
      pc8_q    <= 32'd8;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sleep_q  <= sleep_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
      instr_q  <= instr_d;
      pc8_q    <= pc8_d;
    end
  end

  // Storage needs no reset: the level counter alone says which slots are live.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= new_instr;
      abort_mem[wr_ptr_q] <= i_instr_abort;
      pc_mem[wr_ptr_q]    <= new_pc;
    end
  end

endmodule

// File: doc/zap_fetch_queue.md
ZAP_FETCH_QUEUE -- requirements
Module: zap_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered fetch entries; SHALL be a power of two >= 2.
REQ-002 Parameter PTR_W, default $clog2(DEPTH), pointer width; SHALL be derived from DEPTH, never overridden.
REQ-003 Port i_clk  in  1  sole clock, all state on rising edge.
REQ-004 Port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Port i_clear_from_writeback  in  1  flush, highest priority.
REQ-006 Port i_data_stall  in  1  hold outputs.
REQ-007 Port i_clear_from_alu  in  1  flush, below i_data_stall.
REQ-008 Ports i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode  in  1 each  hold outputs, in that priority order.
REQ-009 Port i_pc_ff  in  32  PC of the instruction presented this cycle.
REQ-010 Port i_cpsr_ff  in  32  CPSR; bit T selects Thumb.
REQ-011 Ports i_instruction  in  32, i_valid  in  1, i_instr_abort  in  1  I-cache return.
REQ-012 Port o_fetch_stall  out  1  queue full; I-cache SHALL hold its return while high.
REQ-013 Ports o_instruction  out  32, o_valid  out  1, o_instr_abort  out  1, o_pc_plus_8_ff  out  32  to decode.
REQ-014 Port o_level  out  PTR_W+1  entries currently queued, excluding the output register.

Function
REQ-015 Push condition: (i_valid or i_instr_abort) and not o_fetch_stall and not sleep and no clear taken this cycle.
REQ-016 Each pushed entry SHALL store instruction (32'd0 if i_instr_abort), abort flag, and i_pc_ff + (T ? 4 : 8) computed at push time.
REQ-017 Pushes SHALL be accepted during any stall; stalls hold only the output register.
REQ-018 Advance = none of i_data_stall, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode asserted, and no clear.
REQ-019 On advance with queue non-empty: output register loads head entry, o_valid=1, head pops.
REQ-020 On advance with queue empty and a push this cycle: entry bypasses to output register directly (1-cycle latency, identical to a non-buffered fetch stage); o_level unchanged.
REQ-021 On advance with queue empty, no push: o_valid=0, o_instruction=0, o_instr_abort=0, o_pc_plus_8_ff held.
REQ-022 Simultaneous push and pop (non-bypass): o_level unchanged; pointers wrap modulo DEPTH.
REQ-023 o_fetch_stall SHALL equal (o_level == DEPTH), combinational from registered level; a pop in the same cycle does not free the slot early.
REQ-024 Pushing an aborted entry SHALL set sleep; while asleep no pushes occur; queued entries still drain normally.
REQ-025 i_clear_from_writeback: empty queue, o_level=0, o_valid=0, o_instr_abort=0, o_instruction=0, sleep=0, o_pc_plus_8_ff held; overrides all other inputs.
REQ-026 i_data_stall without writeback clear: output register and sleep held, i_clear_from_alu ignored that cycle; pushes per REQ-017.
REQ-027 i_clear_from_alu (no writeback clear, no data stall): same effect as REQ-025.
REQ-028 Push attempted while full SHALL be dropped with no state change.

Reset
REQ-029 While i_reset_n=0: o_valid=0, o_instruction=0, o_instr_abort=0, o_pc_plus_8_ff=32'd8, o_level=0, o_fetch_stall=0, sleep=0, pointers=0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; first push after release behaves as from empty.

Verification
REQ-031 Empty queue, ARM, i_pc_ff=0x100, i_valid=1, instr 0xE1A00000, no stall -> next cycle o_valid=1, o_instruction=0xE1A00000, o_pc_plus_8_ff=0x108, o_level=0.
REQ-032 i_stall_from_decode held 6 cycles, pushes each cycle, DEPTH=4 -> o_level reaches 4, o_fetch_stall=1, 5th/6th pushes dropped; release -> 4 entries emerge in order, one per cycle.
REQ-033 Thumb (T=1), i_pc_ff=0x200 -> o_pc_plus_8_ff=0x204.
REQ-034 Push with i_instr_abort=1 -> o_instr_abort=1, o_instruction=0, o_valid=1; later i_valid ignored until i_clear_from_alu, after which pushes resume.
REQ-035 Queue holding 3 entries, i_data_stall=1 and i_clear_from_alu=1 same cycle -> nothing flushed; same with i_clear_from_writeback=1 -> o_level=0, o_valid=0.
REQ-036 Reset pulsed low asynchronously with o_level=2 -> immediately o_level=0, o_valid=0, o_pc_plus_8_ff=8.
